div_sched: RTL
==============

// Module: div_sched
// PURPOSE
//  Multi-channel divider scheduler. Shares one prescaler across NCH channels.
//  The prescaler produces a base tick every PRESCALE clk cycles; 20 ms at 50 MHz by default.
//  Each channel emits a 1-cycle tick strobe every cfg_period base ticks.
//  Sits between the system clock and slow consumers (LED, key-scan, display refresh); sequences start/stop and per-channel config.
// PARAMETERS
//  NCH       4        number of channels (>=1)
//  PRESCALE  1000000  clk cycles per base tick (>=2)
//  PW        8        channel period width, in base ticks
// PORTS
//  clk         in   1            system clock, 50 MHz
//  rst_n       in   1            synchronous reset, active low
//  start       in   1            1-cycle request: run the scheduler
//  stop        in   1            1-cycle request: stop at end of current base period
//  cfg_valid   in   1            config write request
//  cfg_ready   out  1            config write accepted when valid & ready
//  cfg_ch      in   clog2(NCH)   target channel (max(1,clog2(NCH)) bits)
//  cfg_period  in   PW           channel period in base ticks; 0 = channel idle
//  cfg_en      in   1            channel enable
//  busy        out  1            state != IDLE
//  base_tick   out  1            1-cycle prescaler strobe
//  tick        out  NCH          per-channel 1-cycle strobes
//  clk_div     out  NCH          per-channel square waves (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: one clk edge with rst_n low; valid mid-run.
//    - State -> IDLE; prescaler and channel counters -> 0.
//    - All periods and enables -> 0.
//    - busy = base_tick = tick = clk_div = 0; cfg_ready = 1.
//  - FSM, IDLE/RUN/STOPPING:
//    - IDLE: start & !stop -> RUN.
//    - RUN: stop -> STOPPING.
//    - STOPPING: start & !stop -> RUN (cancels the stop); base_tick -> IDLE.
//    - start and stop in the same cycle: stop wins.
//  - Prescaler pcnt runs in RUN/STOPPING and is held at 0 in IDLE.
//    - base_tick is high (combinational) when pcnt == PRESCALE-1; pcnt then wraps to 0.
//    - start sampled in cycle k -> first base_tick in cycle k+PRESCALE.
//  - Channel counter ccnt advances only on base_tick, only when en=1 and period!=0.
//    - At ccnt == period-1: ccnt wraps to 0 and tick is registered high in the next cycle (latency 1).
//    - Otherwise ccnt increments.
//  - Config write (cfg_valid & cfg_ready) loads period and en, clears ccnt, clears clk_div[ch].
//    - cfg_ready = 0 in the base_tick cycle, 1 at all other times.
//    - The accepted write takes effect from the next base_tick.
//  - Entering IDLE: ccnt and clk_div are cleared; periods and enables are retained.
//  - STOPPING -> IDLE base_tick still processes channels; a tick due there is emitted.
// CONFIGURATION
//  DIV_SCHED_SQW_EN defined:
//    - clk_div[ch] toggles (registered) in the same cycle tick[ch] is asserted.
//    - Cleared on config write to ch, on entering IDLE, and on reset.
//  DIV_SCHED_SQW_EN undefined: clk_div is tied to 0 and no toggle flops are built.
// STRUCTURE
//  - div_sched_pkg: FSM state enum (IDLE, RUN, STOPPING) and localparam default PRESCALE/PW.
//  - Sub-module div_sched_chan: holds period, en, ccnt, tick and optional clk_div for one channel.
//    - Instantiated NCH times via generate.
//  - Top level holds the FSM, prescaler and config decode.
// TESTING (PRESCALE=4, NCH=4, PW=8; cycle 0 = start sampled)
//  1 Reset:
//    - rst_n low 2 cycles, stimulus idle -> busy/base_tick/tick/clk_div = 0, cfg_ready = 1.
//    - rst_n low mid-RUN -> all outputs 0 the cycle after the reset edge.
//  2 Basic tick timing:
//    - cfg ch0 period=3 en=1 in IDLE, then start -> base_tick at cycles 4, 8, 12, ...
//    - tick[0] high in cycles 13 and 25 only; tick[3:1] = 0.
//  3 Config collision:
//    - cfg_valid held high through cycle 8 -> cfg_ready = 0 in cycle 8; write accepted in cycle 9.
//    - ccnt restarts from 0 at the next base_tick.
//  4 Stop mid-period:
//    - stop at cycle 6 -> busy high through cycle 8, IDLE from cycle 9, no base_tick after 8.
//    - Additionally, start in cycle 7 -> stays RUN.
//  5 Simultaneous start & stop:
//    - Both in IDLE -> stays IDLE.
//    - Both in RUN -> STOPPING.
//  6 Channel edge cases and macro:
//    - period=0 or en=0 -> no tick ever.
//    - With DIV_SCHED_SQW_EN: clk_div[0] rises in cycle 13, falls in cycle 25.
//    - Without DIV_SCHED_SQW_EN: clk_div[0] stays 0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// div_sched shared types: FSM state encoding and default sizing.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int DEF_PRESCALE = 1000000;
    localparam int DEF_PW       = 8;

endpackage

// File: rtl/div_sched_chan.sv
// One divider channel: period/enable, base-tick counter, tick strobe.
// Optional square-wave output built only with DIV_SCHED_SQW_EN.
module div_sched_chan
    import div_sched_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          base_tick,
    input  logic          clr,
    input  logic          wr,
    input  logic [PW-1:0] wr_period,
    input  logic          wr_en,
    output logic          tick,
    output logic          clk_div
);

    logic [PW-1:0] period;
    logic [PW-1:0] ccnt;
    logic          en;
    logic          adv;
    logic          wrap;

    assign adv  = base_tick & en & (period != '0);
    assign wrap = (ccnt == period - PW'(1));

    // A clear on entry to IDLE still lets the final due tick out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period <= '0;
            en     <= 1'b0;
            ccnt   <= '0;
            tick   <= 1'b0;
        end else begin
            tick <= adv & wrap;
            if (wr) begin
                period <= wr_period;
                en     <= wr_en;
                ccnt   <= '0;
            end else if (clr) begin
                ccnt <= '0;
            end else if (adv) begin
                ccnt <= wrap ? '0 : ccnt + PW'(1);
            end
        end
    end

`ifdef DIV_SCHED_SQW_EN
    logic sqw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sqw <= 1'b0;
        end else if (wr || clr) begin
            sqw <= 1'b0;
        end else if (adv && wrap) begin
            sqw <= ~sqw;
        end
    end

    assign clk_div = sqw;
`else
    assign clk_div = 1'b0;
`endif

endmodule

// File: rtl/div_sched.sv
// Multi-channel divider scheduler: FSM, shared prescaler, config decode.
// Define DIV_SCHED_SQW_EN to build per-channel square-wave outputs.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int PW       = DEF_PW,
    parameter int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [PW-1:0]  cfg_period,
    input  logic           cfg_en,
    output logic           busy,
    output logic           base_tick,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] clk_div
);

    localparam int PCW = $clog2(PRESCALE);

    state_t         state;
    state_t         state_nxt;
    logic [PCW-1:0] pcnt;
    logic           enter_idle;
    logic           cfg_fire;

    assign busy       = (state != IDLE);
    assign base_tick  = busy && (pcnt == PCW'(PRESCALE - 1));
    assign cfg_ready  = ~base_tick;
    assign cfg_fire   = cfg_valid & cfg_ready;
    assign enter_idle = busy && (state_nxt == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start in STOPPING cancels the stop even on the final base tick.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && !stop) state_nxt = RUN;
            end
            RUN: begin
                if (stop) state_nxt = STOPPING;
            end
            STOPPING: begin
                if (start && !stop) state_nxt = RUN;
                else if (base_tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!busy || base_tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCW'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        div_sched_chan #(
            .PW(PW)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .base_tick(base_tick),
            .clr      (enter_idle),
            .wr       (cfg_fire && (cfg_ch == CW'(i))),
            .wr_period(cfg_period),
            .wr_en    (cfg_en),
            .tick     (tick[i]),
            .clk_div  (clk_div[i])
        );
    end

endmodule
